// File: rtl/fifo_pkg.sv
// Shared constants and types for the async_fifo read-side drain stage.
package fifo_pkg;
    localparam int D_WIDTH_DEF = 8;
    localparam int BUF_DEPTH   = 2;
    localparam int OCC_W       = 2;

    typedef logic [D_WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/async_fifo_rd_drain_skid_buf2.sv
// Two-entry in-order skid buffer: head feeds the output, tail absorbs one extra word.
// Push and pop may occur in the same cycle; order is always preserved.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int W = D_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [W-1:0]     head,
    output logic             valid
);
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [W-1:0]     head_q, head_d;
    logic [W-1:0]     tail_q, tail_d;
    logic             xfer;
    logic [OCC_W-1:0] post_occ;

    assign xfer     = pop && (occ_q != '0);
    assign post_occ = occ_q - OCC_W'(xfer);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        // A full buffer that loses its head promotes the tail.
        if (xfer && (occ_q == OCC_W'(BUF_DEPTH))) begin
            head_d = tail_q;
        end
        if (push) begin
            if (post_occ == '0) begin
                head_d = push_data;
            end else begin
                tail_d = push_data;
            end
        end
        occ_d = post_occ + OCC_W'(push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ   = occ_q;
    assign head  = head_q;
    assign valid = (occ_q != '0);
endmodule

// File: rtl/async_fifo_rd_drain.sv
// Pops async_fifo, absorbs its 1-cycle read latency and presents a valid/ready stream.
// Optional RD_DRAIN_CNT_EN adds a 16-bit wrapping count of output transfers (rd_count).
module async_fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int BUF_DEPTH = fifo_pkg::BUF_DEPTH
) (
    input  logic               rclk,
    input  logic               reset,
    input  logic               drain_en,
    input  logic               fifo_empty,
    input  logic [D_WIDTH-1:0] fifo_rd_data,
    output logic               fifo_r_en,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_data,
    input  logic               out_ready,
    output logic               busy
`ifdef RD_DRAIN_CNT_EN
    ,
    output logic [15:0]        rd_count
`endif
);
    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic             xfer;
    logic [2:0]       committed;

    assign xfer = out_valid && out_ready;

    // Words held plus the one landing, minus the one leaving: must stay below capacity.
    assign committed = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, xfer};

    always_comb begin
        fifo_r_en  = drain_en && !fifo_empty && !reset && (committed < 3'(BUF_DEPTH));
        inflight_d = fifo_r_en;
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    skid_buf2 #(
        .W(D_WIDTH)
    ) u_buf (
        .clk       (rclk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (fifo_rd_data),
        .pop       (out_ready),
        .occ       (occ),
        .head      (out_data),
        .valid     (out_valid)
    );

    assign busy = inflight_q || (occ != '0);

`ifdef RD_DRAIN_CNT_EN
    logic [15:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (xfer) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif
endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Self-checking bench: behavioural FIFO source, scoreboard of expected output words.
module tb_async_fifo_rd_drain;
    logic       rclk = 1'b0;
    logic       reset;
    logic       drain_en;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_r_en;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
`ifdef RD_DRAIN_CNT_EN
    logic [15:0] rd_count;
`endif

    always #5 rclk = ~rclk;

    async_fifo_rd_drain #(.D_WIDTH(8), .BUF_DEPTH(2)) dut (
        .rclk         (rclk),
        .reset        (reset),
        .drain_en     (drain_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_r_en    (fifo_r_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy)
`ifdef RD_DRAIN_CNT_EN
        ,
        .rd_count     (rd_count)
`endif
    );

    typedef struct {
        logic drain_en;
        logic out_ready;
        logic exp_r_en;
        logic exp_valid;
        logic exp_busy;
    } vec_t;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pend;
    logic       hold_empty;
    int         n_vec;
    int         n_fail;
    int         n_xfer;
    logic       r_en_seen, valid_seen, busy_seen;
    logic [7:0] data_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One rclk cycle, entered and left on the falling edge.
    task automatic cycle();
        fifo_empty = (src_q.size() == 0) || hold_empty;
        #1;
        r_en_seen  = fifo_r_en;
        valid_seen = out_valid;
        busy_seen  = busy;
        data_seen  = out_data;
        if (out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("spurious_xfer", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        @(posedge rclk);
        if (r_en_seen && src_q.size() != 0) pend = src_q.pop_front();
        @(negedge rclk);
        fifo_rd_data = pend;
    endtask

    task automatic drain_all(input string name, input int max_cycles);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((exp_q.size() != 0 || busy_seen) && n < max_cycles);
        check({name, "_done"}, 32'(exp_q.size() == 0 && !busy_seen), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        check("rst_r_en", 32'(r_en_seen), 32'd0);
        src_q.delete();
        exp_q.delete();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[5];
        int   pops, first_x, last_x;
        n_vec = 0; n_fail = 0; n_xfer = 0;
        reset = 1'b1; drain_en = 1'b1; out_ready = 1'b1; hold_empty = 1'b0;
        fifo_empty = 1'b1; fifo_rd_data = '0; pend = '0;
        @(negedge rclk);

        // Reset state
        load(8'd99);
        cycle();
        check("rst_r_en", 32'(r_en_seen), 32'd0);
        check("rst_valid", 32'(valid_seen), 32'd0);
        check("rst_busy", 32'(busy_seen), 32'd0);
        check("rst_data", 32'(data_seen), 32'd0);
        src_q.delete(); exp_q.delete();
        reset = 1'b0;
        cycle();

        // Basic drain: five consecutive transfers, busy drops the cycle after the last
        foreach (tbl[i]) ;
        load(8'd45); load(8'd23); load(8'd27); load(8'd22); load(8'd12);
        first_x = -1; last_x = -1;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (valid_seen) begin
                if (first_x < 0) first_x = c;
                last_x = c;
            end
            if (c == last_x + 1 && last_x >= 0 && !valid_seen)
                check("basic_busy_fall", 32'(busy_seen), 32'd0);
        end
        check("basic_span", 32'(last_x - first_x), 32'd4);
        check("basic_empty_sb", 32'(exp_q.size()), 32'd0);

        // Backpressure: stall ten cycles, two pops, head held at 45
        out_ready = 1'b0;
        load(8'd45); load(8'd23); load(8'd27);
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (r_en_seen) pops++;
            if (c >= 2) check("bp_hold", 32'(data_seen), 32'd45);
        end
        check("bp_pops", 32'(pops), 32'd2);
        check("bp_valid", 32'(valid_seen), 32'd1);
        out_ready = 1'b1;
        n_xfer = 0;
        drain_all("bp", 20);
        check("bp_count", 32'(n_xfer), 32'd3);

        // Empty boundary: one word, then nothing to pop (table-driven)
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        load(8'd22);
        n_xfer = 0;
        for (int i = 0; i < 5; i++) begin
            drain_en  = tbl[i].drain_en;
            out_ready = tbl[i].out_ready;
            cycle();
            check($sformatf("eb_r_en[%0d]", i), 32'(r_en_seen), 32'(tbl[i].exp_r_en));
            check($sformatf("eb_valid[%0d]", i), 32'(valid_seen), 32'(tbl[i].exp_valid));
            check($sformatf("eb_busy[%0d]", i), 32'(busy_seen), 32'(tbl[i].exp_busy));
        end
        check("eb_xfers", 32'(n_xfer), 32'd1);

        // drain_en drops right after the pop of 14
        load(8'd14); load(8'd33);
        cycle();
        check("de_pop", 32'(r_en_seen), 32'd1);
        drain_en = 1'b0;
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (r_en_seen) pops++;
        end
        check("de_no_pop", 32'(pops), 32'd0);
        check("de_left", 32'(exp_q.size()), 32'd1);
        drain_en = 1'b1;
        drain_all("de", 20);

        // Reset with two words buffered
        out_ready = 1'b0;
        load(8'd27); load(8'd22); load(8'd5);
        for (int c = 0; c < 4; c++) cycle();
        check("mr_full_data", 32'(data_seen), 32'd27);
        reset = 1'b1;
        cycle();
        check("mr_r_en", 32'(r_en_seen), 32'd0);
        src_q.delete(); exp_q.delete();
        reset = 1'b0;
        cycle();
        check("mr_valid", 32'(valid_seen), 32'd0);
        check("mr_busy", 32'(busy_seen), 32'd0);
        check("mr_r_en_after", 32'(r_en_seen), 32'd0);
        out_ready = 1'b1;
        load(8'd7); load(8'd8);
        drain_all("mr", 20);

`ifdef RD_DRAIN_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) load(8'(i + 1));
        drain_all("cnt5", 30);
        check("rd_count_5", 32'(rd_count), 32'd5);
        for (int i = 0; i < 65530; i++) load(8'(i));
        drain_all("cnt_max", 66000);
        check("rd_count_ffff", 32'(rd_count), 32'h0000_FFFF);
        load(8'hA5);
        drain_all("cnt_wrap", 20);
        check("rd_count_wrap", 32'(rd_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/async_fifo_rd_drain.md
Name: async_fifo_rd_drain

Overview:
- Read-side consumer stage sitting directly downstream of async_fifo, in the rclk domain.
- Pops words from the FIFO (r_en/empty/rd_data), absorbs the FIFO's 1-cycle read latency, and presents them as a valid/ready stream.
- Includes a 2-entry skid buffer so a downstream stall never drops a word and sustained throughput is 1 word/cycle.

Parameters:
- D_WIDTH, 8, data word width; must match async_fifo d_width.
- BUF_DEPTH, 2, skid buffer entries; fixed at 2, other values unsupported.

Ports:
- rclk  in  1  read-domain clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- drain_en  in  1  when low, no new pops are issued; in-flight and buffered words still deliver.
- fifo_empty  in  1  async_fifo empty flag (already rclk-synchronous).
- fifo_rd_data  in  D_WIDTH  async_fifo read data, valid exactly 1 rclk cycle after r_en was sampled high with empty low.
- fifo_r_en  out  1  pop request to async_fifo (combinational).
- out_valid  out  1  output word available.
- out_data  out  D_WIDTH  output word, from the head buffer entry.
- out_ready  in  1  downstream accepts when high together with out_valid.
- busy  out  1  high while inflight=1 or occ>0.

Behaviour:
- Clocking/reset: one clock rclk; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, busy=0, occ=0, inflight=0, both buffer entries=0. fifo_r_en=0 while reset is high.
- State:
  - occ: 2-bit count, 0..2.
  - inflight: 1 bit, a pop issued last cycle whose data lands this cycle.
  - head and tail data registers.
- Handshake: a transfer occurs when out_valid && out_ready. out_valid = (occ != 0). out_data = head.
- Pop rule: fifo_r_en = drain_en && !fifo_empty && !reset && (occ + inflight - xfer) < 2, where xfer = out_valid && out_ready.
  - The buffer therefore never overflows.
  - A fifo_r_en=1 cycle sets inflight=1 for the next cycle.
- Capture: when inflight=1, fifo_rd_data is written this cycle.
  - Into head if the post-xfer occupancy is 0, otherwise into tail.
  - On xfer with occ=2, tail shifts into head the same cycle.
- Simultaneous capture + xfer: occ is unchanged; ordering is preserved (FIFO order in = order out).
- Latency: empty FIFO receives a word → fifo_r_en high the first cycle empty is low → out_valid high 2 cycles after that edge (1 FIFO latency + 1 register).
- Throughput: with out_ready held high, one word per cycle.
- Stall: out_ready low → occ fills to 2 and fifo_r_en drops. out_data holds stable while out_valid && !out_ready.
- Empty: fifo_empty high → no pop; buffered words still drain.
- drain_en low mid-burst: stops new pops only. The inflight word is still captured; there is no loss.
- Reset mid-operation: clears buffer and inflight. A word popped in the reset cycle is discarded. The upstream FIFO is reset by the same signal, so no orphaned pointers.
- Width rule: data passes unmodified; no arithmetic on data.

Optional Feature:
- Macro: RD_DRAIN_CNT_EN.
- Defined:
  - Adds output port rd_count (16 bits), the number of completed output transfers (xfer).
  - Reset to 0 by reset; increments by 1 per xfer; wraps 0xFFFF→0x0000.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - D_WIDTH default.
  - BUF_DEPTH constant.
  - Occupancy width constant.
  - typedef for the data word.
- One natural sub-module: skid_buf2 (2-entry in-order buffer with occ, push/pop, head/tail shift). async_fifo_rd_drain wraps it with the pop/inflight control.

Test Plan:
- Basic drain: reset, FIFO holds 45,23,27,22,12, out_ready=1, drain_en=1 → out_data sequence 45,23,27,22,12 on 5 consecutive xfers; busy falls 1 cycle after the last xfer.
- Backpressure: load 45,23,27, out_ready=0 for 10 cycles → exactly 2 pops issued, occ=2, out_data=45 held stable. Release → 45,23,27 delivered in order with no duplicates.
- Empty boundary: single word 22 then fifo_empty=1 → fifo_r_en asserted exactly once; out_valid high exactly one xfer; no pop while empty.
- drain_en toggle: drop drain_en the same cycle as a pop of 14 → 14 still delivered; no further fifo_r_en until drain_en returns.
- Reset mid-operation: assert reset with occ=2 (words 27,22) → next cycle out_valid=0, busy=0, fifo_r_en=0. After release, normal draining resumes.
- RD_DRAIN_CNT_EN build: 5 transfers → rd_count=5; preload to 0xFFFF via 65535 transfers then 1 more → rd_count=0.
